// File: rtl/alu_result_stage.sv
// Registered output stage of the 32-bit ALU: captures the muxed result through
// a valid/ready handshake, derives status flags at capture time, and buffers up
// to two results in a head/tail skid FIFO. Also counts completed results.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic [1:0]        in_sel,
    input  logic              in_carry,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [1:0]        out_sel,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_carry,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  done_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [1:0]       sel;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
    } entry_t;

    entry_t     head;
    entry_t     tail;
    entry_t     new_entry;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2) & ~rst;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flag derivation for the incoming result; carry only meaningful for
    // arith/shift, overflow only for arith.
    always_comb begin
        new_entry        = '0;
        new_entry.result = in_result;
        new_entry.sel    = in_sel;
        new_entry.zero   = (in_result == '0);
        new_entry.neg    = in_result[WIDTH-1];
        new_entry.carry  = ((in_sel == 2'b00) || (in_sel == 2'b10)) ? in_carry : 1'b0;
        new_entry.ovf    = (in_sel == 2'b00) ? in_ovf : 1'b0;
    end

    // FIFO storage, occupancy and completed-result counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            done_count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        head <= new_entry;
                    else
                        tail <= new_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2)
                        head <= tail;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop only occurs with one entry held
                // (full blocks push), so the new entry becomes the head.
                2'b11: head <= new_entry;
                default: ;
            endcase
            if (pop)
                done_count <= done_count + CNT_W'(1);
        end
    end

    // Head entry drives the outputs; holds last popped value when empty.
    always_comb begin
        out_result = head.result;
        out_sel    = head.sel;
        out_zero   = head.zero;
        out_neg    = head.neg;
        out_carry  = head.carry;
        out_ovf    = head.ovf;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based
// reference model of the FIFO and flag rules.
module tb_alu_result_stage;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic [1:0]    in_sel;
    logic          in_carry;
    logic          in_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [1:0]    out_sel;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_ovf;
    logic [CW-1:0] done_count;

    alu_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .in_carry   (in_carry),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] result;
        int           sel;
        bit           zero;
        bit           neg;
        bit           carry;
        bit           ovf;
    } exp_t;

    exp_t q[$];
    int   model_pops;
    int   dut_pops;
    int   tests;
    int   fails;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [W-1:0] res, input int sel, input bit c, input bit o);
        exp_t e;
        e.result = res;
        e.sel    = sel;
        e.zero   = (res == 0);
        e.neg    = (res >= 32'h8000_0000);
        e.carry  = (sel == 0 || sel == 2) ? c : 1'b0;
        e.ovf    = (sel == 0) ? o : 1'b0;
        return e;
    endfunction

    // One clock cycle: drive, check pre-edge outputs against the model,
    // clock, then advance the model.
    task automatic cycle(input bit r, input bit iv, input logic [W-1:0] res,
                         input int sel, input bit c, input bit o, input bit ordy);
        bit   m_ready;
        bit   m_valid;
        exp_t e;
        rst       = r;
        in_valid  = iv;
        in_result = res;
        in_sel    = sel[1:0];
        in_carry  = c;
        in_ovf    = o;
        out_ready = ordy;
        #1;
        m_ready = (q.size() < 2) && !r;
        m_valid = (q.size() > 0);
        check_eq("in_ready", in_ready, m_ready);
        check_eq("out_valid", out_valid, m_valid);
        check_eq("done_count", done_count, model_pops % (1 << CW));
        if (m_valid) begin
            check_eq("out_result", out_result, q[0].result);
            check_eq("out_sel", out_sel, q[0].sel);
            check_eq("out_zero", out_zero, q[0].zero);
            check_eq("out_neg", out_neg, q[0].neg);
            check_eq("out_carry", out_carry, q[0].carry);
            check_eq("out_ovf", out_ovf, q[0].ovf);
        end
        if (out_valid === 1'b1 && ordy && !r)
            dut_pops++;
        @(posedge clk);
        if (r) begin
            q.delete();
            model_pops = 0;
        end else begin
            e = expect_of(res, sel, c, o);
            if (m_valid && ordy) begin
                void'(q.pop_front());
                model_pops++;
            end
            if (iv && m_ready)
                q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, ordy);
    endtask

    function automatic logic [W-1:0] rand_result();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return '0;
        if (k == 1) return 32'h8000_0000;
        return $urandom();
    endfunction

    initial begin
        tests      = 0;
        fails      = 0;
        model_pops = 0;
        dut_pops   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_result  = '0;
        in_sel     = '0;
        in_carry   = 1'b0;
        in_ovf     = 1'b0;
        out_ready  = 1'b0;
        // Bring the DUT out of its unknown power-up state.
        @(posedge clk);
        @(negedge clk);

        // Reset held with in_valid/out_ready high: nothing pushed.
        cycle(1'b1, 1'b1, 32'h1234_5678, 0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'h1234_5678, 0, 1'b1, 1'b1, 1'b1);
        check_eq("rst_result", out_result, 0);
        check_eq("rst_sel", out_sel, 0);
        check_eq("rst_flags", {out_zero, out_neg, out_carry, out_ovf}, 0);
        idle(1'b1);

        // Single pass with zero result, arith op.
        cycle(1'b0, 1'b1, 32'h0, 0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check_eq("single_done", done_count, 1);

        // Flag masking: logic op then shift op on the same value.
        cycle(1'b0, 1'b1, 32'h8000_0001, 1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h8000_0001, 2, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: third offer refused, then re-offered.
        cycle(1'b0, 1'b1, 32'hA, 3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hB, 3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hC, 3, 1'b0, 1'b0, 1'b0);
        check_eq("bp_full_ready", in_ready, 0);
        cycle(1'b0, 1'b1, 32'hC, 3, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'hC, 3, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Streaming: 100 results in, 100 pops in 101 cycles.
        dut_pops = 0;
        for (int i = 0; i < 100; i++)
            cycle(1'b0, 1'b1, rand_result(), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        idle(1'b1);
        check_eq("stream_pops", dut_pops, 100);

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), rand_result(),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Mid-operation reset with both entries full and out_ready high.
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b1, 32'h11, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h22, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h33, 0, 1'b0, 1'b0, 1'b1);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_done", done_count, 0);

        // Wrap: 2^CW pops bring the counter back to zero.
        for (int i = 0; i < (1 << CW); i++)
            cycle(1'b0, 1'b1, rand_result(), $urandom_range(0, 3), 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check_eq("wrap_done", done_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage of the 32-bit ALU. It sits directly downstream of the 4-to-1 result multiplexer. It captures the selected result through a valid/ready handshake, derives the status flags, and buffers up to two results in a skid FIFO, so the ALU never stalls combinationally on the consumer. It also keeps a wrapping count of completed results for debug readback.

## Interface
- WIDTH, 32, data width of result path (≥ 2)
- CNT_W, 16, width of completed-result counter
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- in_valid  input  1  mux output holds a result to capture
- in_ready  output  1  stage can accept a result this cycle
- in_result  input  WIDTH  selected ALU result (mux output)
- in_sel  input  2  mux select that produced the result: 00 arith, 01 logic, 10 shift, 11 compare
- in_carry  input  1  raw carry/borrow from adder or last bit shifted out
- in_ovf  input  1  raw signed overflow from adder
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_result  output  WIDTH  head result
- out_sel  output  2  op class of head result
- out_zero / out_neg / out_carry / out_ovf  output  1 each  flags of head result
- done_count  output  CNT_W  results popped since reset, wraps

## Operation
- Storage: 2-entry FIFO (head, tail), 2-bit occupancy `count` ∈ {0,1,2}. Each entry holds result, sel, and four flags.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- Flags computed at push from input values and stored:
  - zero = (in_result == 0); neg = in_result[WIDTH-1]
  - carry = in_carry when in_sel ∈ {00,10}, else 0
  - ovf = in_ovf when in_sel == 00, else 0
- in_ready = (count != 2) & ~rst. It depends only on registered state, never on out_ready.
- out_valid = (count != 0). out_* fields always reflect the head entry. When count == 0 they hold the last popped value; fields are don't-care while out_valid = 0, except after reset.
- State transitions per cycle:
  - push only: count+1; entry written to head if count was 0, else to tail
  - pop only: count-1; tail moves to head if count was 2
  - push & pop with count == 1: head replaced by new entry, count stays 1
  - push & pop with count == 2: impossible, since in_ready = 0
  - neither: hold
- done_count increments by 1 on every pop. It wraps from 2^CNT_W-1 to 0.
- Inputs are ignored when in_ready = 0, regardless of in_valid.

## Timing
- Reset (rst high at a clk edge) gives count = 0, out_valid = 0, all out_* data/flag fields 0, out_sel = 00, done_count = 0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Reset mid-operation discards both entries with no pop and no done_count increment, even if out_ready is high in that cycle.
- Latency: a result pushed at edge N is on out_* with out_valid = 1 after edge N, when count was 0.
- Throughput: 1 result/cycle sustained when out_ready is held high.
- Backpressure: with out_ready low, accepts exactly 2 results, then drops in_ready. After the first pop, in_ready returns 1 in the next cycle (one-cycle bubble, registered ready).
- out_* fields are stable while out_valid & ~out_ready. Order is strictly FIFO.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1, out_ready = 1 → out_valid = 0, done_count = 0, in_ready = 0 during reset and 1 after release; no push occurs.
- Single pass: push result 0x0000_0000, sel = 00, carry = 1, ovf = 1 → next cycle out_valid = 1, out_zero = 1, out_neg = 0, out_carry = 1, out_ovf = 1; pop → done_count = 1.
- Flag masking: push 0x8000_0001 with sel = 01, carry = 1, ovf = 1 → out_neg = 1, out_zero = 0, out_carry = 0, out_ovf = 0. The same result with sel = 10 → out_carry = 1, out_ovf = 0.
- Backpressure: out_ready = 0, offer 0xA, 0xB, 0xC back-to-back → only 0xA and 0xB accepted and in_ready = 0. Raise out_ready → outputs 0xA, 0xB, then 0xC once re-offered, in order, with no loss or duplication.
- Streaming: 100 consecutive random results with out_ready = 1 → 100 pops in 101 cycles, outputs match a scoreboard model of the flag rules, done_count = 100.
- Mid-operation reset and wrap: fill both entries, assert rst → count = 0, out_valid = 0, done_count = 0. Then preload 2^CNT_W-1 pops (CNT_W = 4 build: 15 pops) plus 1 more → done_count = 0.
